// File: rtl/jteeprom_pkg.sv
// jteeprom_pkg: shared encodings for the 93C46 host and its helpers.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Contents: host command op codes, 2-bit device opcodes, extended
// sub-codes, frame lengths, latched-command struct, frame builder.
package jteeprom_pkg;

  // Host-side command encodings (cmd_op)
  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;
  localparam logic [2:0] OP_EWDS  = 3'd4;
  localparam logic [2:0] OP_ERAL  = 3'd5;
  localparam logic [2:0] OP_WRAL  = 3'd6;
  localparam logic [2:0] OP_ILL   = 3'd7;

  // Device opcodes sent after the start bit
  localparam logic [1:0] DEV_READ  = 2'b10;
  localparam logic [1:0] DEV_WRITE = 2'b01;
  localparam logic [1:0] DEV_ERASE = 2'b11;
  localparam logic [1:0] DEV_EXT   = 2'b00;

  // Extended-op sub-codes carried in the top two address bits
  localparam logic [1:0] SUB_EWEN = 2'b11;
  localparam logic [1:0] SUB_EWDS = 2'b00;
  localparam logic [1:0] SUB_ERAL = 2'b10;
  localparam logic [1:0] SUB_WRAL = 2'b01;

  localparam logic [4:0] FRAME_SHORT = 5'd9;
  localparam logic [4:0] FRAME_LONG  = 5'd25;

  typedef struct packed {
    logic [2:0]  op;
    logic [5:0]  addr;
    logic [15:0] wdata;
  } cmd_t;

  // Ops that program the array and therefore need a ready poll
  function automatic logic is_prog(input logic [2:0] op);
    return (op == OP_WRITE) || (op == OP_ERASE) ||
           (op == OP_ERAL)  || (op == OP_WRAL);
  endfunction

  function automatic logic [4:0] frame_len(input logic [2:0] op);
    return ((op == OP_WRITE) || (op == OP_WRAL)) ? FRAME_LONG : FRAME_SHORT;
  endfunction

  // Full frame left-justified: start, opcode, address, data.
  // Short frames simply stop after the first 9 bits.
  function automatic logic [24:0] frame_word(input cmd_t c);
    logic [1:0]  dop;
    logic [5:0]  fa;
    logic [15:0] fd;
    dop = DEV_EXT;
    fa  = c.addr;
    fd  = '0;
    case (c.op)
      OP_READ:  dop = DEV_READ;
      OP_WRITE: begin dop = DEV_WRITE; fd = c.wdata; end
      OP_ERASE: dop = DEV_ERASE;
      OP_EWEN:  fa = {SUB_EWEN, 4'b0000};
      OP_EWDS:  fa = {SUB_EWDS, 4'b0000};
      OP_ERAL:  fa = {SUB_ERAL, 4'b0000};
      OP_WRAL:  begin fa = {SUB_WRAL, 4'b0000}; fd = c.wdata; end
      default:  ;
    endcase
    return {1'b1, dop, fa, fd};
  endfunction

endpackage

// File: rtl/jt9346_sclk_gen.sv
// jt9346_sclk_gen: DIV-clk half-period divider producing the serial clock.
// Latency: first sclk rise DIV clk after en goes high; strobes are combinational.
// Backpressure: none; runs whenever en is high, clears when en is low.
// Ports: en (run), pulse (1 = toggle sclk, 0 = hold low and act as a
// DIV timer), sclk, rise (first clk of high phase), sample / bit_done
// (last clk of high phase), half_done (last clk of any half-period).
module jt9346_sclk_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic pulse,
  output logic sclk,
  output logic rise,
  output logic sample,
  output logic bit_done,
  output logic half_done
);

  localparam int CW = $clog2(DIV) + 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      // With pulse low the phase never leaves "low", so the counter
      // doubles as a plain DIV-clk timer for cs setup/gap intervals.
      if (last) sclk <= pulse & ~sclk;
    end
  end

  assign rise      = en & sclk & (cnt == '0);
  assign sample    = en & sclk & last;
  assign bit_done  = sample;
  assign half_done = en & last;

endmodule

// File: rtl/jt9346_host.sv
// jt9346_host: single-command master for a 93C46-style 3-wire EEPROM.
// Latency: 1 clk for illegal ops; otherwise frame + read/gap + poll time.
// Backpressure: cmd_ready high only in IDLE; one command in flight.
// Ports: cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata (request),
// rsp_valid/rsp_rdata/rsp_err (one-clk response), busy, and the
// EEPROM bus cs/sclk/di/do_in.
module jt9346_host
  import jteeprom_pkg::*;
#(
  parameter int DIV     = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [5:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        cs,
  output logic        sclk,
  output logic        di,
  input  logic        do_in
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_RDATA = 3'd3;
  localparam logic [2:0] S_CSGAP = 3'd4;
  localparam logic [2:0] S_POLL  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    state;
  cmd_t          cmd;
  logic [23:0]   sreg;     // bits still to send after the one on di
  logic [4:0]    bcnt;     // rises remaining in this frame section
  logic [15:0]   rd_sh;
  logic          gap_ph;   // 0: sclk-low hold with cs high, 1: cs low
  logic          pwait;    // poll setup interval before sampling
  logic [TW-1:0] tcnt;

  logic gen_en, gen_pulse;
  logic rise, sample, bit_done, half_done;
  logic [24:0] fw;

  assign gen_pulse = (state == S_SHIFT) || (state == S_RDATA);
  assign gen_en    = gen_pulse || (state == S_CSGAP) ||
                     ((state == S_POLL) && pwait);
  assign fw        = frame_word(cmd);

  jt9346_sclk_gen #(.DIV(DIV)) u_sclk (
    .clk       (clk),
    .rst       (rst),
    .en        (gen_en),
    .pulse     (gen_pulse),
    .sclk      (sclk),
    .rise      (rise),
    .sample    (sample),
    .bit_done  (bit_done),
    .half_done (half_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cmd       <= '0;
      sreg      <= '0;
      bcnt      <= '0;
      rd_sh     <= '0;
      gap_ph    <= 1'b0;
      pwait     <= 1'b0;
      tcnt      <= '0;
      cs        <= 1'b0;
      di        <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      cmd_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd       <= '{op: cmd_op, addr: cmd_addr, wdata: cmd_wdata};
            cmd_ready <= 1'b0;
            if (cmd_op == OP_ILL) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= S_DONE;
            end else begin
              busy  <= 1'b1;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          di    <= fw[24];
          sreg  <= fw[23:0];
          bcnt  <= frame_len(cmd.op);
          cs    <= 1'b1;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (rise) bcnt <= bcnt - 1'b1;
          if (bit_done) begin
            if (bcnt == '0) begin
              di <= 1'b0;
              if (cmd.op == OP_READ) begin
                bcnt  <= 5'd16;
                state <= S_RDATA;
              end else begin
                gap_ph <= 1'b0;
                state  <= S_CSGAP;
              end
            end else begin
              di   <= sreg[23];
              sreg <= {sreg[22:0], 1'b0};
            end
          end
        end
        S_RDATA: begin
          if (rise)   bcnt  <= bcnt - 1'b1;
          if (sample) rd_sh <= {rd_sh[14:0], do_in};
          if (bit_done && (bcnt == '0)) begin
            gap_ph <= 1'b0;
            state  <= S_CSGAP;
          end
        end
        S_CSGAP: begin
          if (half_done) begin
            if (!gap_ph) begin
              cs     <= 1'b0;
              gap_ph <= 1'b1;
            end else if (is_prog(cmd.op)) begin
              cs    <= 1'b1;
              pwait <= 1'b1;
              tcnt  <= '0;
              state <= S_POLL;
            end else begin
              rsp_valid <= 1'b1;
              busy      <= 1'b0;
              if (cmd.op == OP_READ) rsp_rdata <= rd_sh;
              state <= S_DONE;
            end
          end
        end
        S_POLL: begin
          if (pwait) begin
            if (half_done) pwait <= 1'b0;
          end else if (do_in || (tcnt == TW'(TIMEOUT - 1))) begin
            // A sample of 1 on the final allowed clk still counts as ready
            cs        <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~do_in;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt9346_host.sv
// tb_jt9346_host: directed table plus random commands against a
// behavioural 93C46 device and a word-array reference of its contents.
module tb_jt9346_host;

  localparam int DIV     = 4;
  localparam int TIMEOUT = 4096;
  localparam int BUSY_T  = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [5:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_err, busy, cs, sclk, di, do_in;
  logic [15:0] rsp_rdata;

  always #5 clk = ~clk;

  jt9346_host #(.DIV(DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .cs(cs), .sclk(sclk), .di(di), .do_in(do_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural EEPROM device ----------------
  logic [15:0] dmem [64];
  bit          filled = 0;
  bit          dewen = 0;
  bit          rdop = 0;
  int          dbits = 0;
  int          dbusy = 0;
  logic [24:0] dsh = '0;
  logic [15:0] rdw = '0;
  logic        dpcs = 1'b0, dpsc = 1'b0;
  logic        dev_do = 1'b0;
  bit          tie0 = 0;

  assign do_in = tie0 ? 1'b0 : dev_do;

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 64; i++) dmem[i] = 16'hFFFF;
      filled = 1;
    end
    if (dbusy > 0) dbusy--;
    if (!cs) begin
      if (dpcs) begin
        if (dbits == 9) begin
          if (dsh[7:6] == 2'b11 && dewen) begin
            dmem[dsh[5:0]] = 16'hFFFF; dbusy = BUSY_T;
          end else if (dsh[7:6] == 2'b00) begin
            if (dsh[5:4] == 2'b11) dewen = 1;
            else if (dsh[5:4] == 2'b00) dewen = 0;
            else if (dsh[5:4] == 2'b10 && dewen) begin
              for (int i = 0; i < 64; i++) dmem[i] = 16'hFFFF;
              dbusy = BUSY_T;
            end
          end
        end else if (dbits == 25 && dewen) begin
          if (dsh[23:22] == 2'b01) begin
            dmem[dsh[21:16]] = dsh[15:0]; dbusy = BUSY_T;
          end else if (dsh[23:22] == 2'b00 && dsh[21:20] == 2'b01) begin
            for (int i = 0; i < 64; i++) dmem[i] = dsh[15:0];
            dbusy = BUSY_T;
          end
        end
      end
      dbits = 0; rdop = 0;
      dev_do <= 1'b0;
    end else if (sclk && !dpsc) begin
      dsh = {dsh[23:0], di};
      dbits++;
      if (dbits == 9 && dsh[7:6] == 2'b10) begin
        rdop = 1; rdw = dmem[dsh[5:0]];
      end else if (rdop && dbits > 9 && dbits <= 25) begin
        dev_do <= rdw[25 - dbits];
      end
    end else if (dbits == 0) begin
      dev_do <= (dbusy == 0);
    end
    dpcs = cs; dpsc = sclk;
  end

  // ---------------- bus monitor ----------------
  int   cyc = 0, rises = 0, stray = 0, low_len = 0, last_gap = 0;
  int   cs_rise_cyc = 0, rsp_cyc = 0;
  int   win_q [$];
  logic mpcs = 1'b0, mpsc = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (cs && !mpcs) begin cs_rise_cyc = cyc; last_gap = low_len; end
    if (!cs && mpcs) begin win_q.push_back(rises); rises = 0; end
    if (sclk && !mpsc) begin
      if (cs) rises++; else stray++;
    end
    low_len = cs ? 0 : low_len + 1;
    if (rsp_valid) rsp_cyc = cyc;
    mpcs = cs; mpsc = sclk;
  end

  // ---------------- reference contents ----------------
  logic [15:0] ref_mem [64];
  bit          ref_ewen = 0;

  function automatic bit prog_op(input logic [2:0] op);
    return op == 3'd1 || op == 3'd2 || op == 3'd5 || op == 3'd6;
  endfunction

  function automatic void ref_apply(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d);
    case (op)
      3'd1: if (ref_ewen) ref_mem[a] = d;
      3'd2: if (ref_ewen) ref_mem[a] = 16'hFFFF;
      3'd3: ref_ewen = 1;
      3'd4: ref_ewen = 0;
      3'd5: if (ref_ewen) for (int i = 0; i < 64; i++) ref_mem[i] = 16'hFFFF;
      3'd6: if (ref_ewen) for (int i = 0; i < 64; i++) ref_mem[i] = d;
      default: ;
    endcase
  endfunction

  // rises per cs window: READ = 9 frame + 16 data, long writes 25, rest 9
  function automatic int exp_rises(input logic [2:0] op);
    return (op == 3'd0 || op == 3'd1 || op == 3'd6) ? 25 : 9;
  endfunction

  task automatic do_cmd(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d,
                        output logic [15:0] rd, output logic er, output int lat);
    int t;
    bit busy_ok;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    chk("cmd_ready before issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; busy_ok = 1;
    while (!rsp_valid && lat < 6000) begin
      if (!busy) busy_ok = 0;
      @(negedge clk); lat++;
    end
    chk("rsp_valid seen", rsp_valid, 1);
    rd = rsp_rdata; er = rsp_err;
    if (op != 3'd7) chk("busy held until rsp", busy_ok, 1);
    chk("busy low at rsp", busy, 0);
    @(negedge clk);
    chk("rsp_valid single pulse", rsp_valid, 0);
    @(negedge clk);
  endtask

  task automatic check_bus(input logic [2:0] op);
    int en;
    en = (op == 3'd7) ? 0 : (prog_op(op) ? 2 : 1);
    chk("cs window count", win_q.size(), en);
    if (en >= 1 && win_q.size() >= 1) chk("frame sclk rises", win_q[0], exp_rises(op));
    if (en == 2 && win_q.size() >= 2) begin
      chk("poll sclk rises", win_q[1], 0);
      chk("cs gap >= DIV", last_gap >= DIV, 1);
    end
    win_q.delete();
  endtask

  task automatic run_one(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input logic exp_er);
    logic [15:0] rd;
    logic er;
    int lat;
    do_cmd(op, a, d, rd, er, lat);
    chk("rsp_err", er, exp_er);
    if (op == 3'd0) chk("rsp_rdata", rd, exp_rd);
    ref_apply(op, a, d);
    check_bus(op);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt [$];

  initial begin : main
    logic [15:0] rd, old;
    logic er;
    int lat, s0;
    bit seen;
    logic [2:0] op;
    logic [5:0] a;
    logic [15:0] d;

    for (int i = 0; i < 64; i++) ref_mem[i] = 16'hFFFF;

    vt.push_back('{3'd0, 6'h05, 16'h0000, 16'hFFFF, 1'b0});
    vt.push_back('{3'd3, 6'h00, 16'h0000, 16'h0000, 1'b0});
    vt.push_back('{3'd1, 6'h12, 16'hA55A, 16'h0000, 1'b0});
    vt.push_back('{3'd0, 6'h12, 16'h0000, 16'hA55A, 1'b0});
    vt.push_back('{3'd2, 6'h12, 16'h0000, 16'h0000, 1'b0});
    vt.push_back('{3'd0, 6'h12, 16'h0000, 16'hFFFF, 1'b0});
    vt.push_back('{3'd4, 6'h00, 16'h0000, 16'h0000, 1'b0});
    vt.push_back('{3'd1, 6'h12, 16'h1111, 16'h0000, 1'b0});
    vt.push_back('{3'd0, 6'h12, 16'h0000, 16'hFFFF, 1'b0});
    vt.push_back('{3'd3, 6'h00, 16'h0000, 16'h0000, 1'b0});
    vt.push_back('{3'd6, 6'h00, 16'h1234, 16'h0000, 1'b0});
    vt.push_back('{3'd0, 6'h00, 16'h0000, 16'h1234, 1'b0});
    vt.push_back('{3'd0, 6'h3F, 16'h0000, 16'h1234, 1'b0});
    vt.push_back('{3'd1, 6'h21, 16'h0F0F, 16'h0000, 1'b0});
    vt.push_back('{3'd0, 6'h21, 16'h0000, 16'h0F0F, 1'b0});
    vt.push_back('{3'd7, 6'h00, 16'h0000, 16'h0000, 1'b1});

    // reset state
    repeat (3) @(negedge clk);
    chk("outputs in reset", {cs, sclk, di, rsp_valid, rsp_err, busy, cmd_ready, rsp_rdata}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready after reset", cmd_ready, 1);
    repeat (10) @(negedge clk);

    for (int i = 0; i < vt.size(); i++)
      run_one(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].exp_rd, vt[i].exp_err);

    // illegal op: response one clk after acceptance, no bus activity
    s0 = stray;
    do_cmd(3'd7, 6'h2A, 16'hDEAD, rd, er, lat);
    chk("illegal latency", lat, 1);
    chk("illegal rsp_err", er, 1);
    chk("illegal no cs", win_q.size(), 0);
    chk("illegal no sclk", stray, s0);
    win_q.delete();

    // randomized commands against the reference contents
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3: op = 3'd0;
        4, 5:       op = 3'd1;
        6:          op = 3'd2;
        7, 8:       op = 3'd3;
        9:          op = 3'd4;
        10:         op = ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd5;
        default:    op = 3'd7;
      endcase
      a = 6'($urandom_range(0, 63));
      d = 16'($urandom);
      run_one(op, a, d, ref_mem[a], op == 3'd7);
    end

    // poll timeout with do_in stuck low
    run_one(3'd3, 6'h00, 16'h0000, 16'h0000, 1'b0);
    tie0 = 1;
    do_cmd(3'd1, 6'h33, 16'h5A5A, rd, er, lat);
    tie0 = 0;
    chk("timeout rsp_err", er, 1);
    chk("timeout clk from poll cs rise", rsp_cyc - cs_rise_cyc, DIV + TIMEOUT);
    ref_apply(3'd1, 6'h33, 16'h5A5A);
    check_bus(3'd1);
    run_one(3'd0, 6'h33, 16'h0000, ref_mem[6'h33], 1'b0);

    // reset in the middle of a WRITE frame
    old = ref_mem[6'h12];
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 6'h12; cmd_wdata = ~old;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("cs high mid frame", cs, 1);
    #2 rst = 1'b1;
    #1 chk("abort pins low", {cs, sclk, di, busy, cmd_ready}, 0);
    seen = 0;
    repeat (5) begin @(negedge clk); if (rsp_valid) seen = 1; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (rsp_valid) seen = 1; end
    chk("no rsp after abort", seen, 0);
    win_q.delete();
    run_one(3'd0, 6'h12, 16'h0000, old, 1'b0);

    chk("sclk rises outside cs", stray, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1);
  end

endmodule

// File: doc/jt9346_host.md
Name: jt9346_host

Overview:
- Parallel-command master that drives the 3-wire serial bus (cs, sclk, di, do) of a 93C46-compatible 64x16 EEPROM device.
- Sits directly upstream of the EEPROM device model. Replaces CPU bit-banging: the CPU or game logic issues one command, and the block serialises the frame, captures read data, polls ready/busy and returns a single response.

Parameters:
- DIV, 4: clk cycles per sclk half-period. Must be ≥2 so the device's sclk edge detector (sampled on clk) sees every edge.
- TIMEOUT, 4096: maximum clk cycles spent polling ready before the command is flagged as an error.

Ports:
- clk        in   1   system clock
- rst        in   1   reset
- cmd_valid  in   1   command request
- cmd_ready  out  1   block can accept a command
- cmd_op     in   3   0 READ, 1 WRITE, 2 ERASE, 3 EWEN, 4 EWDS, 5 ERAL, 6 WRAL, 7 illegal
- cmd_addr   in   6   word address
- cmd_wdata  in   16  write data for WRITE and WRAL
- rsp_valid  out  1   one-cycle completion pulse
- rsp_rdata  out  16  read data; valid with rsp_valid after READ
- rsp_err    out  1   qualifies rsp_valid: ready-poll timeout or illegal op
- busy       out  1   high from command accept until rsp_valid
- cs         out  1   EEPROM chip select, active high
- sclk       out  1   EEPROM serial clock
- di         out  1   EEPROM serial data in
- do_in      in   1   EEPROM serial data out / ready

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - Outputs during reset: cs=0, sclk=0, di=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, cmd_ready=0.
  - cmd_ready=1 on the first clk after reset is released.
  - Reset asserted mid-command aborts the command with no response. The EEPROM sees cs fall, which its protocol allows.
- Handshake:
  - A command is accepted on a clk edge where cmd_valid and cmd_ready are both high.
  - cmd_ready is high only in IDLE.
  - Op, address and data are latched at acceptance.
- Frame contents, MSB first:
  - Start bit 1, then 2 opcode bits, then 6 address bits.
  - Opcodes: READ 10+addr; WRITE 01+addr; ERASE 11+addr; EWEN 00 11 0000; EWDS 00 00 0000; ERAL 00 10 0000; WRAL 00 01 0000.
  - WRITE and WRAL then append 16 data bits, MSB first.
  - Frame lengths: 9 bits for most ops, 25 bits for WRITE and WRAL.
- Bit timing:
  - sclk idles low. di changes only on the clk where sclk goes low or at the start of the bit slot.
  - Each bit is DIV clk with sclk low followed by DIV clk with sclk high.
  - cs rises DIV clk before the first sclk rise.
- READ:
  - After the 9-bit frame, generate 16 more sclk pulses with di=0.
  - Sample do_in on the last clk of each high phase and shift it into rsp_rdata LSB-first-in (first sample = bit 15).
- Completion:
  - After the last bit, hold sclk low for DIV clk, then drop cs for DIV clk (CSGAP).
- Poll (WRITE, ERASE, ERAL, WRAL only):
  - Raise cs, wait DIV clk, then sample do_in every clk.
  - do_in=1 → finish normally.
  - TIMEOUT samples without do_in=1 → finish with rsp_err=1.
  - cs drops on finish.
- Illegal op (7): rsp_valid and rsp_err asserted on the clk after acceptance; no bus activity.
- Response outputs:
  - rsp_valid is a single-clk pulse.
  - rsp_rdata holds its value until the next READ completes.
  - rsp_err is valid only with rsp_valid.
- No EWEN tracking: the block does not track whether EWEN has been issued. WRITE/ERASE without EWEN is forwarded to the device unchanged.
- State machine:
  - IDLE → LOAD (build shift word and bit count) → SHIFT → [RDATA if READ] → CSGAP → [POLL if write-type] → DONE → IDLE.
- Counters:
  - Half-period counter: ceil(log2 DIV)+1 bits.
  - Bit counter: 5 bits.
  - Timeout counter: width sized from TIMEOUT.

Decomposition:
- Shared package jteeprom_pkg:
  - cmd_op encodings (OP_READ..OP_WRAL).
  - 2-bit device opcodes and the 2-bit sub-codes for EWEN/EWDS/ERAL/WRAL.
  - Frame length constants 9 and 25.
- One natural sub-module, jt9346_sclk_gen: DIV half-period divider producing sclk, a rise strobe, a "sample" strobe (last clk of the high phase) and a "bit done" strobe.

Test Plan:
- After reset, wait for the device's power-up fill, then READ addr 0x05 → rsp_valid, rsp_err=0, rsp_rdata=0xFFFF; exactly 25 sclk rising edges in one cs window.
- EWEN, WRITE 0x12=0xA55A, READ 0x12:
  - Read returns 0xA55A.
  - Write frame shows 25 sclk rises, then a cs low gap ≥DIV clk, then a cs-high poll.
- ERASE 0x12, READ 0x12 → 0xFFFF. EWDS completes in a 9-rise frame with no poll phase.
- WRAL 0x1234 (after EWEN), READ 0x00 and READ 0x3F → 0x1234 both. busy stays high until the poll sees do_in=1.
- Replace the device with do_in tied 0, issue WRITE → rsp_valid with rsp_err=1 exactly TIMEOUT clk after poll sampling starts. cmd_op=7 → rsp_err pulse 1 clk after acceptance, no sclk activity.
- Assert rst during SHIFT of a WRITE → cs, sclk and di go low immediately (asynchronously), no rsp_valid. Following READ returns the old word unchanged.
